// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// One 64-bit CPU access in flight; whole 128-bit lines move over the memory
// channel. fence_i writes back every dirty line and then invalidates the cache.
module dcache_dm_wb #(
  parameter int IDX_W   = 6,
  parameter int PADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  cpu_req_addr,
  input  logic         cpu_req_rw,
  input  logic         cpu_req_valid,
  input  logic [63:0]  cpu_data_write,
  input  logic [7:0]   cpu_wmask,
  output logic [63:0]  cpu_data_read,
  output logic         cpu_ready,
  output logic         cache_idle,
  output logic [63:0]  rw_addr_o,
  output logic         rw_req_o,
  output logic         rw_valid_o,
  output logic [127:0] rw_w_data_o,
  input  logic [127:0] data_read_i,
  input  logic         rw_ready_i,
  input  logic         fence_i,
  output logic         fence_done
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = PADDR_W - 4 - IDX_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, REFILL, RESP, FL_SCAN, FL_WB, FL_DONE
  } state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        rw;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  state_t             state;
  req_t               req;
  logic [IDX_W-1:0]   fidx;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];

  logic [IDX_W-1:0]   ridx;
  logic [TAG_W-1:0]   rtag;
  logic               hit;
  logic [127:0]       line_cur;
  logic [63:0]        half;
  logic [63:0]        merged;
  logic [127:0]       line_new;
  logic [63:0]        victim_addr;
  logic [63:0]        flush_addr;

  assign cache_idle = (state == IDLE);
  assign ridx       = req.addr[4+IDX_W-1:4];
  assign rtag       = req.addr[PADDR_W-1:4+IDX_W];

  // Hit detection, half-line select and byte-merge for stores on the request line
  always_comb begin
    hit         = valid_q[ridx] && (tag_q[ridx] == rtag);
    line_cur    = data_q[ridx];
    half        = req.addr[3] ? line_cur[127:64] : line_cur[63:0];
    merged      = half;
    for (int i = 0; i < 8; i++)
      if (req.wmask[i]) merged[i*8 +: 8] = req.wdata[i*8 +: 8];
    line_new    = req.addr[3] ? {merged, line_cur[63:0]} : {line_cur[127:64], merged};
    victim_addr = {{(64-PADDR_W){1'b0}}, tag_q[ridx], ridx, 4'b0};
    flush_addr  = {{(64-PADDR_W){1'b0}}, tag_q[fidx], fidx, 4'b0};
  end

  // Controller: memory states raise rw_valid_o one cycle after entry, hold it until rw_ready_i
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req           <= '0;
      fidx          <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      cpu_ready     <= 1'b0;
      cpu_data_read <= '0;
      rw_valid_o    <= 1'b0;
      rw_req_o      <= 1'b0;
      rw_addr_o     <= '0;
      rw_w_data_o   <= '0;
      fence_done    <= 1'b0;
    end else begin
      cpu_ready  <= 1'b0;
      fence_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fence_i) begin
            fidx  <= '0;
            state <= FL_SCAN;
          end else if (cpu_req_valid) begin
            req   <= '{addr: cpu_req_addr, rw: cpu_req_rw, wdata: cpu_data_write, wmask: cpu_wmask};
            state <= LOOKUP;
          end
        end
        // RESP always hits: the line was installed on the previous edge
        LOOKUP, RESP: begin
          if (hit) begin
            if (req.rw) begin
              data_q[ridx]  <= line_new;
              dirty_q[ridx] <= 1'b1;
            end else begin
              cpu_data_read <= half;
            end
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else if (valid_q[ridx] && dirty_q[ridx]) begin
            state <= WB;
          end else begin
            state <= REFILL;
          end
        end
        WB: begin
          if (!rw_valid_o) begin
            rw_valid_o  <= 1'b1;
            rw_req_o    <= 1'b1;
            rw_addr_o   <= victim_addr;
            rw_w_data_o <= data_q[ridx];
          end else if (rw_ready_i) begin
            rw_valid_o <= 1'b0;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (!rw_valid_o) begin
            rw_valid_o <= 1'b1;
            rw_req_o   <= 1'b0;
            rw_addr_o  <= {req.addr[63:4], 4'b0};
          end else if (rw_ready_i) begin
            rw_valid_o    <= 1'b0;
            data_q[ridx]  <= data_read_i;
            tag_q[ridx]   <= rtag;
            valid_q[ridx] <= 1'b1;
            dirty_q[ridx] <= 1'b0;
            state         <= RESP;
          end
        end
        FL_SCAN: begin
          if (valid_q[fidx] && dirty_q[fidx]) state <= FL_WB;
          else if (&fidx)                     state <= FL_DONE;
          else                                fidx  <= fidx + 1'b1;
        end
        FL_WB: begin
          if (!rw_valid_o) begin
            rw_valid_o  <= 1'b1;
            rw_req_o    <= 1'b1;
            rw_addr_o   <= flush_addr;
            rw_w_data_o <= data_q[fidx];
          end else if (rw_ready_i) begin
            rw_valid_o    <= 1'b0;
            dirty_q[fidx] <= 1'b0;
            if (&fidx) state <= FL_DONE;
            else begin
              fidx  <= fidx + 1'b1;
              state <= FL_SCAN;
            end
          end
        end
        FL_DONE: begin
          valid_q    <= '0;
          fence_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_dm_wb.sv
// Directed bench for dcache_dm_wb with a small line-memory responder.
module tb_dcache_dm_wb;
  logic         clk = 0;
  logic         rst = 1;
  logic [63:0]  cpu_req_addr = '0;
  logic         cpu_req_rw = 0;
  logic         cpu_req_valid = 0;
  logic [63:0]  cpu_data_write = '0;
  logic [7:0]   cpu_wmask = '0;
  logic [63:0]  cpu_data_read;
  logic         cpu_ready;
  logic         cache_idle;
  logic [63:0]  rw_addr_o;
  logic         rw_req_o;
  logic         rw_valid_o;
  logic [127:0] rw_w_data_o;
  logic [127:0] data_read_i = '0;
  logic         rw_ready_i = 0;
  logic         fence_i = 0;
  logic         fence_done;

  int tests = 0, fails = 0;
  int overlap = 0;
  bit mem_hold = 0;
  int dly = 0;
  logic [63:0]  log_addr[$];
  logic         log_req[$];
  logic [127:0] log_data[$];

  dcache_dm_wb dut (
    .clk(clk), .rst(rst), .cpu_req_addr(cpu_req_addr), .cpu_req_rw(cpu_req_rw),
    .cpu_req_valid(cpu_req_valid), .cpu_data_write(cpu_data_write), .cpu_wmask(cpu_wmask),
    .cpu_data_read(cpu_data_read), .cpu_ready(cpu_ready), .cache_idle(cache_idle),
    .rw_addr_o(rw_addr_o), .rw_req_o(rw_req_o), .rw_valid_o(rw_valid_o),
    .rw_w_data_o(rw_w_data_o), .data_read_i(data_read_i), .rw_ready_i(rw_ready_i),
    .fence_i(fence_i), .fence_done(fence_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_line(input logic [63:0] a);
    if (a == 64'h8000_0010) return 128'h11111111_22222222_33333333_44444444;
    return {a[31:0], 32'hDEAD0000, a[31:0], 32'h0000BEEF};
  endfunction

  // Memory responder: answers each request two cycles after it appears, logs it
  always @(negedge clk) begin
    if (rw_ready_i) rw_ready_i = 0;
    else if (rw_valid_o && !mem_hold && !rst) begin
      if (dly == 2) begin
        rw_ready_i  = 1;
        data_read_i = mem_line(rw_addr_o);
        log_addr.push_back(rw_addr_o);
        log_req.push_back(rw_req_o);
        log_data.push_back(rw_w_data_o);
        dly = 0;
      end else dly++;
    end else dly = 0;
  end

  always @(negedge clk) if (cpu_ready && fence_done) overlap++;

  task automatic clear_log();
    log_addr.delete(); log_req.delete(); log_data.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cache_idle && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (!cache_idle) begin fails++; $display("FAIL wait_idle: cache_idle=%0b required 1", cache_idle); end
  endtask

  task automatic cpu_access(input logic [63:0] a, input logic rw, input logic [63:0] wd,
                            input logic [7:0] m, output logic [63:0] rd, output int lat);
    wait_idle();
    cpu_req_addr = a; cpu_req_rw = rw; cpu_data_write = wd; cpu_wmask = m; cpu_req_valid = 1;
    @(posedge clk); #1 cpu_req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ready && lat < 500);
    rd = cpu_data_read;
    tests++;
    if (!cpu_ready) begin fails++; $display("FAIL cpu_ready_timeout: addr=%h waited %0d cycles", a, lat); end
  endtask

  task automatic pulse_fence();
    int n = 0;
    wait_idle();
    fence_i = 1;
    @(posedge clk); #1 fence_i = 0;
    do begin @(negedge clk); n++; end while (!fence_done && n < 1000);
    tests++;
    if (!fence_done) begin fails++; $display("FAIL fence_timeout: fence_done=0 after %0d cycles", n); end
  endtask

  task automatic test_reset();
    tests++; if (cache_idle !== 1'b1) begin fails++; $display("FAIL rst_idle: got %b want 1", cache_idle); end
    tests++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
    tests++; if (cpu_data_read !== 64'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", cpu_data_read); end
    tests++; if (rw_valid_o !== 1'b0 || rw_req_o !== 1'b0) begin fails++; $display("FAIL rst_rw: valid=%b req=%b want 0/0", rw_valid_o, rw_req_o); end
    tests++; if (rw_addr_o !== 64'h0 || rw_w_data_o !== 128'h0) begin fails++; $display("FAIL rst_rwbus: addr=%h data=%h want 0", rw_addr_o, rw_w_data_o); end
    tests++; if (fence_done !== 1'b0) begin fails++; $display("FAIL rst_fence_done: got %b want 0", fence_done); end
  endtask

  task automatic test_refill();
    logic [63:0] rd; int lat;
    clear_log();
    cpu_access(64'h8000_0010, 0, '0, '0, rd, lat);
    tests++; if (log_addr.size() != 1) begin fails++; $display("FAIL refill_count: got %0d want 1", log_addr.size()); end
    else begin
      tests++; if (log_addr[0] !== 64'h8000_0010 || log_req[0] !== 1'b0) begin fails++; $display("FAIL refill_req: addr=%h rw=%b want 80000010/0", log_addr[0], log_req[0]); end
    end
    tests++; if (rd !== 64'h33333333_44444444) begin fails++; $display("FAIL refill_data: got %h want 3333333344444444", rd); end
  endtask

  task automatic test_hit();
    logic [63:0] rd; int lat;
    clear_log();
    cpu_access(64'h8000_0010, 0, '0, '0, rd, lat);
    tests++; if (log_addr.size() != 0) begin fails++; $display("FAIL hit_nomem: got %0d requests want 0", log_addr.size()); end
    tests++; if (lat != 2) begin fails++; $display("FAIL hit_latency: got %0d want 2", lat); end
    tests++; if (rd !== 64'h33333333_44444444) begin fails++; $display("FAIL hit_data: got %h want 3333333344444444", rd); end
  endtask

  task automatic test_writeback();
    logic [63:0] rd; int lat;
    clear_log();
    cpu_access(64'h8000_0018, 1, 64'h0000_0000_0000_AABB, 8'h03, rd, lat);
    tests++; if (lat != 2 || log_addr.size() != 0) begin fails++; $display("FAIL store_hit: lat=%0d reqs=%0d want 2/0", lat, log_addr.size()); end
    cpu_access(64'h8000_0418, 0, '0, '0, rd, lat);
    tests++; if (log_addr.size() != 2) begin fails++; $display("FAIL wb_count: got %0d want 2", log_addr.size()); end
    else begin
      tests++; if (log_addr[0] !== 64'h8000_0010 || log_req[0] !== 1'b1) begin fails++; $display("FAIL wb_req: addr=%h rw=%b want 80000010/1", log_addr[0], log_req[0]); end
      tests++; if (log_data[0] !== 128'h11111111_2222AABB_33333333_44444444) begin fails++; $display("FAIL wb_data: got %h want 111111112222aabb3333333344444444", log_data[0]); end
      tests++; if (log_addr[1] !== 64'h8000_0410 || log_req[1] !== 1'b0) begin fails++; $display("FAIL wb_refill: addr=%h rw=%b want 80000410/0", log_addr[1], log_req[1]); end
    end
    tests++; if (rd !== 64'h80000410_DEAD0000) begin fails++; $display("FAIL wb_load: got %h want 80000410dead0000", rd); end
  endtask

  task automatic test_fence();
    logic [63:0] rd; int lat;
    cpu_access(64'h8000_0000, 1, 64'h01234567_89ABCDEF, 8'hFF, rd, lat);
    cpu_access(64'h8000_0050, 1, 64'h0, 8'h01, rd, lat);
    clear_log();
    pulse_fence();
    tests++; if (log_addr.size() != 2) begin fails++; $display("FAIL fence_count: got %0d want 2", log_addr.size()); end
    else begin
      tests++; if (log_addr[0] !== 64'h8000_0000 || log_req[0] !== 1'b1) begin fails++; $display("FAIL fence_wb0: addr=%h rw=%b want 80000000/1", log_addr[0], log_req[0]); end
      tests++; if (log_data[0] !== 128'h80000000_DEAD0000_01234567_89ABCDEF) begin fails++; $display("FAIL fence_wb0_data: got %h", log_data[0]); end
      tests++; if (log_addr[1] !== 64'h8000_0050 || log_req[1] !== 1'b1) begin fails++; $display("FAIL fence_wb5: addr=%h rw=%b want 80000050/1", log_addr[1], log_req[1]); end
    end
    clear_log();
    cpu_access(64'h8000_0000, 0, '0, '0, rd, lat);
    tests++; if (log_addr.size() != 1) begin fails++; $display("FAIL fence_inval: got %0d requests want 1", log_addr.size()); end
    tests++; if (rd !== 64'h80000000_0000BEEF) begin fails++; $display("FAIL fence_reload: got %h want 800000000000beef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; int lat; int n = 0;
    cpu_access(64'h8000_0060, 0, '0, '0, rd, lat);
    mem_hold = 1;
    wait_idle();
    cpu_req_addr = 64'h8000_0020; cpu_req_rw = 0; cpu_req_valid = 1;
    @(posedge clk); #1 cpu_req_valid = 0;
    do begin @(negedge clk); n++; end while (!rw_valid_o && n < 50);
    tests++; if (rw_valid_o !== 1'b1 || rw_req_o !== 1'b0 || rw_addr_o !== 64'h8000_0020) begin
      fails++; $display("FAIL mid_refill: valid=%b rw=%b addr=%h want 1/0/80000020", rw_valid_o, rw_req_o, rw_addr_o); end
    rst = 1;
    @(posedge clk); #1;
    tests++; if (rw_valid_o !== 1'b0 || cache_idle !== 1'b1) begin fails++; $display("FAIL mid_rst: valid=%b idle=%b want 0/1", rw_valid_o, cache_idle); end
    @(negedge clk); rst = 0; mem_hold = 0;
    clear_log();
    cpu_access(64'h8000_0060, 0, '0, '0, rd, lat);
    tests++; if (log_addr.size() != 1) begin fails++; $display("FAIL mid_rst_miss: got %0d requests want 1", log_addr.size()); end
  endtask

  task automatic test_fence_and_req();
    int n = 0; int early = 0;
    wait_idle();
    fence_i = 1; cpu_req_addr = 64'h8000_0030; cpu_req_rw = 0; cpu_req_valid = 1;
    @(posedge clk); #1 fence_i = 0;
    do begin @(negedge clk); n++; if (cpu_ready) early++; end while (!fence_done && n < 1000);
    tests++; if (!fence_done || early != 0) begin fails++; $display("FAIL fence_first: fence_done=%b early_ready=%0d want 1/0", fence_done, early); end
    @(posedge clk); #1 cpu_req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 500);
    tests++; if (!cpu_ready || cpu_data_read !== 64'h80000030_0000BEEF) begin
      fails++; $display("FAIL fence_then_req: ready=%b data=%h want 1/800000300000beef", cpu_ready, cpu_data_read); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_reset();
    test_refill();
    test_hit();
    test_writeback();
    test_fence();
    test_reset_mid();
    test_fence_and_req();
    tests++; if (overlap != 0) begin fails++; $display("FAIL ready_fence_overlap: got %0d want 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
